riscv_icache: RTL and testbench
===============================

// Module: riscv_icache
// PURPOSE
//   Direct-mapped, read-only instruction cache directly upstream of RISCV_IF.
//   Serves IF fetch requests through the ICACHE_* handshake.
//   Refills whole 128-bit lines from slow instruction memory.
//   Raises proc_stall on a miss until the line is installed; IF holds pc and injects NOP meanwhile.
// PARAMETERS
//   INDEX_W    3    line index bits; line count = 2**INDEX_W (default 8 lines)
//   ADDR_W     32   processor byte-address width
//   TAG_W      ADDR_W-INDEX_W-4   derived; not overridable
// PORTS
//   clk          in   1     single clock, rising edge
//   rst          in   1     synchronous, active-high reset
//   proc_ren     in   1     fetch request; IF ties high
//   proc_wen     in   1     ignored (read-only cache)
//   proc_addr    in   32    byte address; [1:0] ignored, [3:2] word-in-line, [3+INDEX_W:4] index, rest tag
//   proc_wdata   in   32    ignored
//   proc_rdata   out  32    fetched instruction
//   proc_stall   out  1     1 = rdata not valid this cycle
//   mem_read     out  1     line-read request to memory
//   mem_write    out  1     tied 0
//   mem_addr     out  28    line address = proc_addr[31:4]
//   mem_wdata    out  128   tied 0
//   mem_rdata    in   128   refill line; word w = mem_rdata[32*w+31:32*w]
//   mem_ready    in   1     one-cycle pulse; mem_rdata valid in the same cycle
// BEHAVIOUR
//   Arrays: valid[2**INDEX_W], tag[TAG_W], data[128] per line. Valid bits are cleared on rst; tag/data are not reset.
//   FSM states:
//     IDLE (compare)
//     ALLOC (refill in flight)
//   Encoding: 1-bit register, IDLE=0.
//   IDLE:
//     hit = proc_ren & valid[idx] & tag match.
//     Hit: proc_stall=0, proc_rdata=data[idx] word [3:2], combinational same cycle (zero-latency hit).
//     proc_ren=0: proc_stall=0, proc_rdata=0, no state change.
//     Miss: proc_stall=1, proc_rdata=0. Capture mem_addr<=proc_addr[31:4]. Next state ALLOC.
//   ALLOC:
//     mem_read=1 (registered: state==ALLOC); mem_addr held stable.
//     proc_stall=1, proc_rdata=0.
//     On mem_ready: write data/tag, set valid; next state IDLE, mem_read drops next edge.
//   Miss penalty: 1 compare cycle + memory latency + 1 re-compare cycle (the re-compare hits).
//   Address rule: proc_addr is held stable by IF while proc_stall=1. Refill always uses the captured mem_addr, never the live proc_addr.
//   mem_ready outside ALLOC is ignored.
//   Reset values:
//     state=IDLE, mem_read=0, mem_addr=0, mem_write=0, mem_wdata=0, all valid=0.
//     After reset the first fetch with proc_ren=1 therefore misses (proc_stall=1).
//   Reset mid-refill: FSM returns to IDLE and mem_read=0 at the next edge. No line is written. A late mem_ready is ignored.
//   proc_wen=1: treated as a read (wen ignored); no array update.
// CONFIGURATION
//   ICACHE_PERF_CNT_EN
//     Defined: adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0], both reset to 0.
//       hit: +1 per IDLE cycle with hit.
//       miss: +1 per IDLE->ALLOC transition.
//       Both saturate at 32'hFFFF_FFFF.
//     Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//   Shared package riscv_pkg: NOP (32'h00000013), LINE_W=128, WORD_OFF_W=2, ICACHE state encoding localparams.
//   Sub-module icache_line_array:
//     valid/tag/data storage; one write port.
//     Combinational read at index; synchronous valid clear on rst.
//   Top holds FSM, hit compare, word select, memory handshake, optional counters.
// TESTING
//   T1 cold miss:
//     rst 2 cycles, then proc_addr=0x0000_0000.
//     Expect proc_stall=1, mem_read=1 next cycle with mem_addr=0.
//     mem_ready after 5 cycles with line {W3..W0}.
//     Expect proc_stall=0 and rdata=W0 one cycle later.
//   T2 same-line hits: addrs 0x4, 0x8, 0xC after T1.
//     Expect rdata W1, W2, W3 with proc_stall=0 every cycle and mem_read=0.
//   T3 conflict:
//     Load 0x0000_0000, then 0x0000_0080 (same index 0 when INDEX_W=3, different tag) -> miss and refill.
//     Then 0x0 again -> miss (eviction).
//   T4 reset mid-refill:
//     Assert rst while in ALLOC.
//     Expect mem_read=0 next cycle; the line is not valid; a stray mem_ready is ignored.
//     Re-fetch of the same addr misses.
//   T5 proc_ren=0: any addr -> proc_stall=0, mem_read stays 0, no state change.
//   T6 (ICACHE_PERF_CNT_EN) run T1+T2 -> perf_miss_cnt=1, perf_hit_cnt=4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, cache line geometry and
// the instruction-cache FSM state encoding.
package riscv_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int          LINE_W     = 128;
  localparam int          WORD_OFF_W = 2;

  localparam logic ICACHE_IDLE_ENC  = 1'b0;
  localparam logic ICACHE_ALLOC_ENC = 1'b1;

  typedef enum logic {
    ICACHE_IDLE  = ICACHE_IDLE_ENC,
    ICACHE_ALLOC = ICACHE_ALLOC_ENC
  } icache_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One combinational read port, one synchronous write port; only valid bits reset.
module icache_line_array
  import riscv_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data are never reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/riscv_icache.sv
// Direct-mapped read-only instruction cache in front of RISCV_IF, refilling
// 128-bit lines. Optional hit/miss counters: define ICACHE_PERF_CNT_EN.
module riscv_icache
  import riscv_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_ren,
  input  logic              proc_wen,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-5:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hit_cnt,
  output logic [31:0]       perf_miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - 4;

  icache_state_e state;

  logic [INDEX_W-1:0]    req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_OFF_W-1:0] word_sel;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [LINE_W-1:0]     line_data;
  logic [3:0][31:0]      line_words;
  logic                  hit;
  logic                  miss;
  logic                  refill_we;
  logic                  unused_inputs;

  assign req_idx    = proc_addr[INDEX_W+3:4];
  assign req_tag    = proc_addr[ADDR_W-1:INDEX_W+4];
  assign word_sel   = proc_addr[3:2];
  assign line_words = line_data;

  assign hit  = proc_ren && (state == ICACHE_IDLE) && line_valid && (line_tag == req_tag);
  assign miss = proc_ren && (state == ICACHE_IDLE) && !hit;

  // Refill targets the captured line address, never the live fetch address.
  assign refill_we = (state == ICACHE_ALLOC) && mem_ready && !rst;

  icache_line_array #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_lines (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (req_idx),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .we      (refill_we),
    .wr_idx  (mem_addr[INDEX_W-1:0]),
    .wr_tag  (mem_addr[ADDR_W-5:INDEX_W]),
    .wr_data (mem_rdata)
  );

  always_comb begin
    proc_rdata = '0;
    if (hit) begin
      proc_rdata = line_words[word_sel];
    end
  end

  assign proc_stall = (state == ICACHE_ALLOC) || miss;
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ICACHE_IDLE;
      mem_read <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        ICACHE_IDLE: begin
          if (miss) begin
            state    <= ICACHE_ALLOC;
            mem_read <= 1'b1;
            mem_addr <= proc_addr[ADDR_W-1:4];
          end
        end
        ICACHE_ALLOC: begin
          if (mem_ready) begin
            state    <= ICACHE_IDLE;
            mem_read <= 1'b0;
          end
        end
        default: begin
          state    <= ICACHE_IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Counters saturate rather than wrap so long runs never report small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (hit && (perf_hit_cnt != 32'hFFFF_FFFF)) begin
        perf_hit_cnt <= perf_hit_cnt + 32'd1;
      end
      if (miss && (perf_miss_cnt != 32'hFFFF_FFFF)) begin
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      end
    end
  end
`endif

  assign unused_inputs = ^{proc_wen, proc_wdata, proc_addr[1:0]};

endmodule

// File: tb/tb_riscv_icache.sv
// Directed self-checking bench for riscv_icache; refill lines carry word
// values {line_addr, word, 2'b01} so each hit value is known by hand.
module tb_riscv_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_ren;
  logic         proc_wen;
  logic [31:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  perf_hit_cnt;
  logic [31:0]  perf_miss_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  riscv_icache dut (
    .clk       (clk),
    .rst       (rst),
    .proc_ren  (proc_ren),
    .proc_wen  (proc_wen),
    .proc_addr (proc_addr),
    .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata),
    .proc_stall(proc_stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .perf_hit_cnt (perf_hit_cnt),
    .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] make_line(input logic [27:0] la);
    logic [127:0] l;
    logic [1:0]   wv;
    l = '0;
    for (int w = 0; w < 4; w++) begin
      wv = 2'(w);
      l[32*w +: 32] = {la, wv, 2'b01};
    end
    return l;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready(input logic [27:0] la);
    mem_ready = 1'b1;
    mem_rdata = make_line(la);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    #2;
    vectors++;
    if (mem_read !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mem_read got=%b want=0", mem_read);
    end
    vectors++;
    if (mem_addr !== 28'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_mem_addr got=%h want=0", mem_addr);
    end
    vectors++;
    if ((mem_write !== 1'b0) || (mem_wdata !== 128'h0)) begin
      miscompares++;
      $display("[TB] FAIL reset_mem_write got=%b/%h want=0/0", mem_write, mem_wdata);
    end
    vectors++;
    if ((proc_stall !== 1'b0) || (proc_rdata !== 32'h0)) begin
      miscompares++;
      $display("[TB] FAIL reset_idle got stall=%b rdata=%h want 0/0", proc_stall, proc_rdata);
    end
`ifdef ICACHE_PERF_CNT_EN
    vectors++;
    if ((perf_hit_cnt !== 32'd0) || (perf_miss_cnt !== 32'd0)) begin
      miscompares++;
      $display("[TB] FAIL reset_perf got=%0d/%0d want=0/0", perf_hit_cnt, perf_miss_cnt);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss;
    proc_ren  = 1'b1;
    proc_addr = 32'h0000_0000;
    #2;
    vectors++;
    if ((proc_stall !== 1'b1) || (proc_rdata !== 32'h0) || (mem_read !== 1'b0)) begin
      miscompares++;
      $display("[TB] FAIL cold_compare got stall=%b rdata=%h rd=%b want 1/0/0", proc_stall, proc_rdata, mem_read);
    end
    tick();
    #2;
    vectors++;
    if ((mem_read !== 1'b1) || (mem_addr !== 28'h0) || (proc_stall !== 1'b1)) begin
      miscompares++;
      $display("[TB] FAIL cold_alloc got rd=%b addr=%h stall=%b want 1/0/1", mem_read, mem_addr, proc_stall);
    end
    repeat (4) tick();
    #2;
    vectors++;
    if ((proc_stall !== 1'b1) || (mem_read !== 1'b1)) begin
      miscompares++;
      $display("[TB] FAIL cold_wait got stall=%b rd=%b want 1/1", proc_stall, mem_read);
    end
    pulse_ready(28'h0);
    #2;
    vectors++;
    if ((proc_stall !== 1'b0) || (proc_rdata !== 32'h0000_0001) || (mem_read !== 1'b0)) begin
      miscompares++;
      $display("[TB] FAIL cold_recompare got stall=%b rdata=%h rd=%b want 0/00000001/0", proc_stall, proc_rdata, mem_read);
    end
    tick();
  endtask

  task automatic test_same_line;
    logic [31:0] addrs [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] exp   [3] = '{32'h5, 32'h9, 32'hD};
    for (int i = 0; i < 3; i++) begin
      proc_addr = addrs[i];
      #2;
      vectors++;
      if ((proc_stall !== 1'b0) || (proc_rdata !== exp[i]) || (mem_read !== 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL same_line_%0d got stall=%b rdata=%h rd=%b want 0/%h/0", i, proc_stall, proc_rdata, mem_read, exp[i]);
      end
      tick();
    end
    proc_ren = 1'b0;
    #2;
`ifdef ICACHE_PERF_CNT_EN
    vectors++;
    if ((perf_hit_cnt !== 32'd4) || (perf_miss_cnt !== 32'd1)) begin
      miscompares++;
      $display("[TB] FAIL perf_counts got hit=%0d miss=%0d want 4/1", perf_hit_cnt, perf_miss_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_conflict;
    proc_ren  = 1'b1;
    proc_addr = 32'h0000_0080;
    #2;
    vectors++;
    if (proc_stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL conflict_miss got stall=%b want 1", proc_stall);
    end
    tick();
    #2;
    vectors++;
    if ((mem_read !== 1'b1) || (mem_addr !== 28'h8)) begin
      miscompares++;
      $display("[TB] FAIL conflict_alloc got rd=%b addr=%h want 1/0000008", mem_read, mem_addr);
    end
    tick();
    pulse_ready(28'h8);
    #2;
    vectors++;
    if ((proc_stall !== 1'b0) || (proc_rdata !== 32'h0000_0081)) begin
      miscompares++;
      $display("[TB] FAIL conflict_hit got stall=%b rdata=%h want 0/00000081", proc_stall, proc_rdata);
    end
    tick();
    proc_addr = 32'h0000_0000;
    #2;
    vectors++;
    if (proc_stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL evicted_miss got stall=%b want 1", proc_stall);
    end
    tick();
    #2;
    vectors++;
    if (mem_addr !== 28'h0) begin
      miscompares++;
      $display("[TB] FAIL evicted_addr got=%h want 0", mem_addr);
    end
    tick();
    pulse_ready(28'h0);
    #2;
    vectors++;
    if ((proc_stall !== 1'b0) || (proc_rdata !== 32'h0000_0001)) begin
      miscompares++;
      $display("[TB] FAIL reload_hit got stall=%b rdata=%h want 0/00000001", proc_stall, proc_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_refill;
    proc_ren  = 1'b1;
    proc_addr = 32'h0000_0030;
    tick();
    #2;
    vectors++;
    if ((mem_read !== 1'b1) || (mem_addr !== 28'h3)) begin
      miscompares++;
      $display("[TB] FAIL mid_alloc got rd=%b addr=%h want 1/0000003", mem_read, mem_addr);
    end
    rst      = 1'b1;
    proc_ren = 1'b0;
    tick();
    rst = 1'b0;
    #2;
    vectors++;
    if ((mem_read !== 1'b0) || (mem_addr !== 28'h0) || (proc_stall !== 1'b0)) begin
      miscompares++;
      $display("[TB] FAIL mid_reset got rd=%b addr=%h stall=%b want 0/0/0", mem_read, mem_addr, proc_stall);
    end
    pulse_ready(28'h3);
    #2;
    vectors++;
    if (mem_read !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL late_ready got rd=%b want 0", mem_read);
    end
    proc_ren  = 1'b1;
    proc_addr = 32'h0000_0030;
    #2;
    vectors++;
    if (proc_stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_refetch got stall=%b want 1", proc_stall);
    end
    tick();
    tick();
    pulse_ready(28'h3);
    #2;
    vectors++;
    if ((proc_stall !== 1'b0) || (proc_rdata !== 32'h0000_0031)) begin
      miscompares++;
      $display("[TB] FAIL mid_refill_hit got stall=%b rdata=%h want 0/00000031", proc_stall, proc_rdata);
    end
    tick();
  endtask

  task automatic test_ren_low;
    logic [31:0] addrs [3] = '{32'h30, 32'h0, 32'h84};
    proc_ren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      proc_addr = addrs[i];
      #2;
      vectors++;
      if ((proc_stall !== 1'b0) || (proc_rdata !== 32'h0) || (mem_read !== 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL ren_low_%0d got stall=%b rdata=%h rd=%b want 0/0/0", i, proc_stall, proc_rdata, mem_read);
      end
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = {4{32'hDEAD_BEEF}};
    proc_addr = 32'h0000_0030;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #2;
    vectors++;
    if (mem_read !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_ready got rd=%b want 0", mem_read);
    end
    proc_ren   = 1'b1;
    proc_wen   = 1'b1;
    proc_wdata = 32'hCAFE_F00D;
    proc_addr  = 32'h0000_0038;
    #2;
    vectors++;
    if ((proc_stall !== 1'b0) || (proc_rdata !== 32'h0000_0039)) begin
      miscompares++;
      $display("[TB] FAIL wen_read got stall=%b rdata=%h want 0/00000039", proc_stall, proc_rdata);
    end
    tick();
    proc_wen  = 1'b0;
    proc_addr = 32'h0000_0030;
    #2;
    vectors++;
    if ((proc_stall !== 1'b0) || (proc_rdata !== 32'h0000_0031)) begin
      miscompares++;
      $display("[TB] FAIL line_intact got stall=%b rdata=%h want 0/00000031", proc_stall, proc_rdata);
    end
    tick();
    proc_ren = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    proc_ren   = 1'b0;
    proc_wen   = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    test_reset();
    test_cold_miss();
    test_same_line();
    test_conflict();
    test_reset_mid_refill();
    test_ren_low();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
